// File: rtl/world_map_arbiter.sv
// world_map_arbiter
//
// Shares the single-port world/maze map RAM (2-bit pixels, synchronous
// 1-cycle read) between the VGA pixel fetch path (vid) and the ball
// collision probe (col). vid has priority. A bounded-wait counter forces a
// col grant after MAX_WAIT-1 consecutive denials, which drops that cycle's
// vid request. Each read carries an owner tag so the data returns to the
// right requester with a fixed 3-cycle latency.
//
// Timing of a grant decided in cycle N:
//   N+1  map_en/map_addr, col_ack, vid_drop
//   N+2  map_data from the RAM
//   N+3  vid_valid or col_valid pulse with the pixel
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   vid_req/row/col         single-cycle video fetch request
//   vid_valid, vid_pixel    returned video pixel; the pixel holds between pulses
//   vid_drop                pulse: a vid request lost to a forced col grant
//   col_req/row/col         level probe request, held until col_valid
//   col_ack                 pulse on the cycle after a col grant
//   col_valid, col_pixel    returned probe pixel; the pixel holds between pulses
//   map_en, map_addr        RAM read port, map_addr = {row, col}
//   map_data                RAM read data, one cycle after map_en
//   drop_count              saturating count of vid_drop pulses
//   state_dbg               last grant owner (0 IDLE, 1 VID, 2 COL)
//
// Build option: define WORLD_MAP_ARB_STATS_EN to build the drop_count
// counter. Without it, drop_count is tied to zero.
//
// Handshake: vid has no back-pressure. A vid request that is not serviced is
// reported on vid_drop and is not retried. col_req is a level that is held
// with a stable address. col_ack marks its grant. While the read is in flight
// (from the grant until the col_valid cycle), col_req is ignored. A col_req
// that is still high on the cycle after col_valid is a new request.
module world_map_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_row,
  input  logic [ADDR_W-1:0]   vid_col,
  output logic                vid_valid,
  output logic [1:0]          vid_pixel,
  output logic                vid_drop,
  input  logic                col_req,
  input  logic [ADDR_W-1:0]   col_row,
  input  logic [ADDR_W-1:0]   col_col,
  output logic                col_ack,
  output logic                col_valid,
  output logic [1:0]          col_pixel,
  output logic                map_en,
  output logic [2*ADDR_W-1:0] map_addr,
  input  logic [1:0]          map_data,
  output logic [15:0]         drop_count,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    COL  = 2'd2
  } owner_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  owner_t     state, next_state;
  owner_t     grant;
  owner_t     tag0, tag1;
  logic [7:0] wait_cnt, wait_next;
  logic       drop_next;
  logic       col_in_flight;

  // The col_valid cycle still counts as in flight. The requester keeps
  // col_req high during that cycle, and it must not trigger a second read.
  assign col_in_flight = (tag0 == COL) || (tag1 == COL) || col_valid;
  assign state_dbg     = state;

  // Grant decision for this cycle. This block also computes the next owner
  // and the next wait count.
  always_comb begin
    grant      = IDLE;
    drop_next  = 1'b0;
    next_state = state;
    wait_next  = wait_cnt;

    if (col_req && !col_in_flight && (wait_cnt == WAIT_LIMIT)) begin
      grant     = COL;
      drop_next = vid_req;
    end else if (vid_req) begin
      grant = VID;
    end else if (col_req && !col_in_flight) begin
      grant = COL;
    end

    if (grant != IDLE) next_state = grant;

    if (!col_req || (grant == COL)) begin
      wait_next = 8'd0;
    end else if (!col_in_flight && (wait_cnt != WAIT_LIMIT)) begin
      wait_next = wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
    end
  end

  // RAM request stage and the owner tag pipeline. tag0 lines up with
  // map_en, and tag1 lines up with map_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_en   <= 1'b0;
      map_addr <= '0;
      col_ack  <= 1'b0;
      vid_drop <= 1'b0;
      tag0     <= IDLE;
      tag1     <= IDLE;
    end else begin
      map_en   <= (grant != IDLE);
      col_ack  <= (grant == COL);
      vid_drop <= drop_next;
      tag0     <= grant;
      tag1     <= tag0;
      if (grant == COL)      map_addr <= {col_row, col_col};
      else if (grant == VID) map_addr <= {vid_row, vid_col};
    end
  end

  // Output stage: steer the returned pixel by its tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_valid <= 1'b0;
      col_valid <= 1'b0;
      vid_pixel <= 2'b00;
      col_pixel <= 2'b00;
    end else begin
      vid_valid <= (tag1 == VID);
      col_valid <= (tag1 == COL);
      if (tag1 == VID) vid_pixel <= map_data;
      if (tag1 == COL) col_pixel <= map_data;
    end
  end

`ifdef WORLD_MAP_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 16'd0;
    end else if (vid_drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_world_map_arbiter.sv
module tb_world_map_arbiter;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_row, vid_col;
  logic          vid_valid;
  logic [1:0]    vid_pixel;
  logic          vid_drop;
  logic          col_req;
  logic [AW-1:0] col_row, col_col;
  logic          col_ack, col_valid;
  logic [1:0]    col_pixel;
  logic          map_en;
  logic [2*AW-1:0] map_addr;
  logic [1:0]    map_data;
  logic [15:0]   drop_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  world_map_arbiter #(.ADDR_W(AW), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
    .vid_valid(vid_valid), .vid_pixel(vid_pixel), .vid_drop(vid_drop),
    .col_req(col_req), .col_row(col_row), .col_col(col_col),
    .col_ack(col_ack), .col_valid(col_valid), .col_pixel(col_pixel),
    .map_en(map_en), .map_addr(map_addr), .map_data(map_data),
    .drop_count(drop_count), .state_dbg(state_dbg)
  );

  // Map contents: pixel at (row, col) is (row + col) mod 4.
  function automatic logic [1:0] pix(input logic [AW-1:0] r, input logic [AW-1:0] c);
    logic [AW:0] s;
    s = {1'b0, r} + {1'b0, c};
    return s[1:0];
  endfunction

  // Synchronous-read RAM model.
  always @(posedge clk) begin
    if (map_en) map_data <= pix(map_addr[2*AW-1:AW], map_addr[AW-1:0]);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0; vid_row = '0; vid_col = '0;
    col_req = 1'b0; col_row = '0; col_col = '0;
  endtask

  task automatic test_reset();
    logic [1:0] expp;
    reset = 1'b1;
    idle_inputs();
    vid_req = 1'b1; col_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({vid_valid, vid_pixel, vid_drop, col_ack, col_valid, col_pixel,
           map_en, map_addr, drop_count, state_dbg} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: vv=%b vp=%b vd=%b ca=%b cv=%b cp=%b en=%b addr=%h dc=%0d st=%0d required all 0",
                 i, vid_valid, vid_pixel, vid_drop, col_ack, col_valid, col_pixel,
                 map_en, map_addr, drop_count, state_dbg);
      end
    end
    reset = 1'b0;
    col_req = 1'b0;
    vid_req = 1'b1; vid_row = 7'd3; vid_col = 7'd4;
    expp = pix(7'd3, 7'd4);
    step();
    vid_req = 1'b0;
    checks++;
    if (map_en !== 1'b1 || map_addr !== {7'd3, 7'd4}) begin
      errors++;
      $display("FAIL reset_first_addr: en=%b addr=%h required en=1 addr=%h", map_en, map_addr, {7'd3, 7'd4});
    end
    step();
    checks++;
    if (vid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_early_valid: vid_valid=%b required 0", vid_valid);
    end
    step();
    checks++;
    if (vid_valid !== 1'b1 || vid_pixel !== expp) begin
      errors++;
      $display("FAIL reset_first_vid: vid_valid=%b vid_pixel=%b required 1 %b", vid_valid, vid_pixel, expp);
    end
    step();
  endtask

  task automatic test_col_single();
    col_req = 1'b1; col_row = 7'd5; col_col = 7'd9;
    step();
    checks++;
    if (col_ack !== 1'b1 || map_addr !== {7'd5, 7'd9}) begin
      errors++;
      $display("FAIL col_ack: ack=%b addr=%h required 1 %h", col_ack, map_addr, {7'd5, 7'd9});
    end
    step();
    checks++;
    if (col_ack !== 1'b0) begin
      errors++;
      $display("FAIL col_ack_pulse: ack=%b required 0", col_ack);
    end
    step();
    checks++;
    if (col_valid !== 1'b1 || col_pixel !== 2'b10 || vid_valid !== 1'b0) begin
      errors++;
      $display("FAIL col_valid: cv=%b cp=%b vv=%b required 1 10 0", col_valid, col_pixel, vid_valid);
    end
    // col_req still high on the col_valid cycle must not start a new read.
    step();
    col_req = 1'b0;
    checks++;
    if (col_ack !== 1'b0 || col_valid !== 1'b0 || map_en !== 1'b0) begin
      errors++;
      $display("FAIL col_no_regrant: ack=%b cv=%b en=%b required 0 0 0", col_ack, col_valid, map_en);
    end
    step();
  endtask

  task automatic test_toggle();
    int ack_cyc = -1, cv_cyc = -1, acks = 0, drops = 0;
    logic [1:0] cp = 2'b00;
    col_row = 7'd10; col_col = 7'd20;
    for (int k = 0; k < 12; k++) begin
      vid_req = (k < 8) && (k % 2 == 0);
      vid_row = 7'(k); vid_col = 7'd0;
      col_req = (k <= 4);
      step();
      if (col_ack) begin acks++; ack_cyc = k + 1; end
      if (vid_drop) drops++;
      if (col_valid) begin cv_cyc = k + 1; cp = col_pixel; end
    end
    checks++;
    if (ack_cyc !== 2 || acks !== 1) begin
      errors++;
      $display("FAIL toggle_ack: ack_cycle=%0d acks=%0d required 2 1", ack_cyc, acks);
    end
    checks++;
    if (cv_cyc !== 4 || cp !== 2'b10) begin
      errors++;
      $display("FAIL toggle_col_valid: cycle=%0d pixel=%b required 4 10", cv_cyc, cp);
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL toggle_drops: drops=%0d required 0", drops);
    end
  endtask

  task automatic test_reset_mid();
    int cvs = 0;
    col_req = 1'b1; col_row = 7'd2; col_col = 7'd3;
    step();
    checks++;
    if (col_ack !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ack: ack=%b required 1", col_ack);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({col_ack, col_valid, map_en, state_dbg} !== 5'd0) begin
      errors++;
      $display("FAIL midreset_clear: ack=%b cv=%b en=%b st=%0d required 0", col_ack, col_valid, map_en, state_dbg);
    end
    step();
    step();
    col_req = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (col_valid) cvs++;
    end
    checks++;
    if (cvs !== 0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL midreset_after: col_valids=%0d state=%0d required 0 0", cvs, state_dbg);
    end
  endtask

  task automatic test_starve();
    int ack_cyc = -1, drop_cyc = -1, drops = 0, cv_cyc = -1;
    logic [2*AW-1:0] addr8 = '0;
    logic [1:0] cp = 2'b00, vp11 = 2'b00;
    logic vv10 = 1'b1, vv11 = 1'b0;
    col_row = 7'd1; col_col = 7'd2;
    for (int k = 0; k < 14; k++) begin
      vid_req = 1'b1; vid_row = 7'(k); vid_col = 7'(k + 1);
      col_req = (k <= 10);
      step();
      if (col_ack) ack_cyc = k + 1;
      if (vid_drop) begin drops++; drop_cyc = k + 1; end
      if (col_valid) begin cv_cyc = k + 1; cp = col_pixel; end
      if (k + 1 == 8) addr8 = map_addr;
      if (k + 1 == 10) vv10 = vid_valid;
      if (k + 1 == 11) begin vv11 = vid_valid; vp11 = vid_pixel; end
    end
    vid_req = 1'b0;
    col_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (ack_cyc !== 8 || addr8 !== {7'd1, 7'd2}) begin
      errors++;
      $display("FAIL starve_ack: ack_cycle=%0d addr=%h required 8 %h", ack_cyc, addr8, {7'd1, 7'd2});
    end
    checks++;
    if (drops !== 1 || drop_cyc !== 8) begin
      errors++;
      $display("FAIL starve_drop: drops=%0d cycle=%0d required 1 8", drops, drop_cyc);
    end
    checks++;
    if (cv_cyc !== 10 || cp !== pix(7'd1, 7'd2)) begin
      errors++;
      $display("FAIL starve_col_valid: cycle=%0d pixel=%b required 10 %b", cv_cyc, cp, pix(7'd1, 7'd2));
    end
    checks++;
    if (vv10 !== 1'b0 || vv11 !== 1'b1 || vp11 !== pix(7'd8, 7'd9)) begin
      errors++;
      $display("FAIL starve_vid_resume: vv10=%b vv11=%b vp11=%b required 0 1 %b", vv10, vv11, vp11, pix(7'd8, 7'd9));
    end
  endtask

  task automatic test_stats();
    int drops = 0;
    logic [15:0] exp_dc;
    col_row = 7'd6; col_col = 7'd6;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 12; k++) begin
        vid_req = 1'b1; vid_row = 7'(k); vid_col = 7'd0;
        col_req = (k <= 10);
        step();
        if (vid_drop) drops++;
      end
    end
    vid_req = 1'b0;
    col_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (drops !== 2) begin
      errors++;
      $display("FAIL stats_drops: drops=%0d required 2", drops);
    end
`ifdef WORLD_MAP_ARB_STATS_EN
    exp_dc = 16'd3;
`else
    exp_dc = 16'd0;
`endif
    checks++;
    if (drop_count !== exp_dc) begin
      errors++;
      $display("FAIL drop_count: got %0d required %0d", drop_count, exp_dc);
    end
  endtask

  initial begin
    test_reset();
    test_col_single();
    test_toggle();
    test_reset_mid();
    test_starve();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
